// File: rtl/rf_arbiter_if.sv
// -----------------------------------------------------------------------------
// rf_arbiter_if
// Request/response bundle for one client of the register-file arbiter.
//   req    : request, level. Held with op/addr/addr2/wdata until ack.
//   op     : 00 READ, 01 WRITE, 10 MOVE, 11 NOP
//   addr   : READ/WRITE target, MOVE source
//   addr2  : MOVE destination
//   wdata  : WRITE data
//   ack    : one-cycle completion pulse
//   rdata  : registered READ/MOVE result
// Modports: master = requesting client, slave = arbiter.
// -----------------------------------------------------------------------------
interface rf_arbiter_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic          req;
  logic [1:0]    op;
  logic [AW-1:0] addr;
  logic [AW-1:0] addr2;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (output req, op, addr, addr2, wdata, input ack, rdata);
  modport slave  (input req, op, addr, addr2, wdata, output ack, rdata);
endinterface

// File: rtl/rf_arbiter.sv
// -----------------------------------------------------------------------------
// rf_arbiter
// Two-requester round-robin arbiter and access sequencer for a register file
// with single select, write-enable load and combinational read.
//
// Ports:
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-low reset
//   a, b     : requester bundles (rf_arbiter_if.slave)
//   rf_load  : register file write enable
//   rf_sel   : register file select
//   rf_d     : register file write data
//   rf_q     : register file read data (combinational from rf_sel)
//   busy     : high whenever the sequencer is not idle
//
// Optional feature macro: RF_ARB_MOVE_EN
//   defined   : opcode 10 copies register addr into addr2 (extra MOVE_WR cycle)
//   undefined : opcode 10 behaves as NOP; addr2 is ignored
// -----------------------------------------------------------------------------
module rf_arbiter #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  rf_arbiter_if.slave   a,
  rf_arbiter_if.slave   b,
  output logic          rf_load,
  output logic [AW-1:0] rf_sel,
  output logic [DW-1:0] rf_d,
  input  logic [DW-1:0] rf_q,
  output logic          busy
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
`ifdef RF_ARB_MOVE_EN
  localparam logic [1:0] OP_MOVE  = 2'b10;
`endif

`ifdef RF_ARB_MOVE_EN
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MOVE_WR, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
`endif

  state_t        r_state;
  state_t        w_state_next;
  logic          r_last_grant;   // 0 = A, 1 = B
  logic          r_grant;        // requester being served
  logic [1:0]    r_op;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_a_rdata;
  logic [DW-1:0] r_b_rdata;
`ifdef RF_ARB_MOVE_EN
  logic [AW-1:0] r_addr2;
  logic [DW-1:0] r_tmp;
`endif

  logic w_any_req;
  logic w_pick_b;
  logic w_a_ack;
  logic w_b_ack;

  assign w_any_req = a.req | b.req;
  // B wins when it is alone, or on a tie when A was served last.
  assign w_pick_b  = b.req & (~a.req | ~r_last_grant);

  // ---------------------------------------------------------------------------
  // State register and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_op         <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_a_rdata    <= '0;
      r_b_rdata    <= '0;
`ifdef RF_ARB_MOVE_EN
      r_addr2      <= '0;
      r_tmp        <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          // Capture the winner's command so the requester may change its
          // inputs freely once ack has been seen.
          if (w_any_req) begin
            r_grant <= w_pick_b;
            r_op    <= w_pick_b ? b.op    : a.op;
            r_addr  <= w_pick_b ? b.addr  : a.addr;
            r_wdata <= w_pick_b ? b.wdata : a.wdata;
`ifdef RF_ARB_MOVE_EN
            r_addr2 <= w_pick_b ? b.addr2 : a.addr2;
`endif
          end
        end
        S_EXEC: begin
          if (r_op == OP_READ) begin
            if (r_grant) r_b_rdata <= rf_q;
            else         r_a_rdata <= rf_q;
          end
`ifdef RF_ARB_MOVE_EN
          if (r_op == OP_MOVE) r_tmp <= rf_q;
`endif
        end
`ifdef RF_ARB_MOVE_EN
        S_MOVE_WR: begin
          if (r_grant) r_b_rdata <= r_tmp;
          else         r_a_rdata <= r_tmp;
        end
`endif
        S_DONE: r_last_grant <= r_grant;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and register-file/handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    rf_load      = 1'b0;
    rf_sel       = '0;
    rf_d         = '0;
    w_a_ack      = 1'b0;
    w_b_ack      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) w_state_next = S_EXEC;
      end
      S_EXEC: begin
        rf_sel = r_addr;
        case (r_op)
          OP_WRITE: begin
            rf_load      = 1'b1;
            rf_d         = r_wdata;
            w_state_next = S_DONE;
          end
`ifdef RF_ARB_MOVE_EN
          OP_MOVE:  w_state_next = S_MOVE_WR;
`endif
          // READ captures rf_q in the register block; NOP (and MOVE when
          // the feature is absent) just completes.
          default:  w_state_next = S_DONE;
        endcase
      end
`ifdef RF_ARB_MOVE_EN
      S_MOVE_WR: begin
        rf_sel       = r_addr2;
        rf_d         = r_tmp;
        rf_load      = 1'b1;
        w_state_next = S_DONE;
      end
`endif
      S_DONE: begin
        w_a_ack      = ~r_grant;
        w_b_ack      = r_grant;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign a.ack   = w_a_ack;
  assign b.ack   = w_b_ack;
  assign a.rdata = r_a_rdata;
  assign b.rdata = r_b_rdata;
  assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_rf_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_arbiter
// Self-checking bench for rf_arbiter. A behavioural register file sits on the
// rf_* port; a separate transaction-level model (array of register values,
// last-served requester, per-requester rdata) predicts each ack latency and
// rdata value. Latency is counted in clock cycles from the idle cycle that
// samples req up to and including the ack cycle.
// -----------------------------------------------------------------------------
module tb_rf_arbiter;
  localparam int DW = 8;
  localparam int AW = 3;
`ifdef RF_ARB_MOVE_EN
  localparam bit MOVE_EN = 1'b1;
`else
  localparam bit MOVE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rf_arbiter_if #(.DW(DW), .AW(AW)) a_if ();
  rf_arbiter_if #(.DW(DW), .AW(AW)) b_if ();

  logic          rf_load;
  logic [AW-1:0] rf_sel;
  logic [DW-1:0] rf_d;
  logic [DW-1:0] rf_q;
  logic          busy;

  rf_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk     (clk),
    .reset   (reset),
    .a       (a_if.slave),
    .b       (b_if.slave),
    .rf_load (rf_load),
    .rf_sel  (rf_sel),
    .rf_d    (rf_d),
    .rf_q    (rf_q),
    .busy    (busy)
  );

  // Behavioural register file sharing the arbiter's reset.
  logic [DW-1:0] rf_mem [8];
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) rf_mem[i] <= '0;
    end else if (rf_load) begin
      rf_mem[rf_sel] <= rf_d;
    end
  end
  assign rf_q = rf_mem[rf_sel];

  int load_cnt = 0;
  always @(negedge clk) if (rf_load === 1'b1) load_cnt++;

  int n_vec = 0;
  int n_err = 0;

  // Transaction-level reference model
  logic [7:0] ref_mem [8];
  logic [7:0] ref_rd [2];
  bit         ref_last;   // 0 = A, 1 = B

  function automatic int op_cycles(input logic [1:0] op);
    return (op == 2'b10 && MOVE_EN) ? 4 : 3;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    ref_rd[0] = '0;
    ref_rd[1] = '0;
    ref_last  = 1'b1;
  endtask

  task automatic model_apply(input bit who, input logic [1:0] op, input logic [2:0] ad,
                             input logic [2:0] ad2, input logic [7:0] wd, output logic [7:0] exp_rd);
    case (op)
      2'b00: ref_rd[who] = ref_mem[ad];
      2'b01: ref_mem[ad] = wd;
      2'b10: if (MOVE_EN) begin
        ref_rd[who]  = ref_mem[ad];
        ref_mem[ad2] = ref_mem[ad];
      end
      default: ;
    endcase
    ref_last = who;
    exp_rd   = ref_rd[who];
  endtask

  task automatic drive(input bit who, input logic [1:0] op, input logic [2:0] ad,
                       input logic [2:0] ad2, input logic [7:0] wd, input logic req);
    if (!who) begin
      a_if.op = op; a_if.addr = ad; a_if.addr2 = ad2; a_if.wdata = wd; a_if.req = req;
    end else begin
      b_if.op = op; b_if.addr = ad; b_if.addr2 = ad2; b_if.wdata = wd; b_if.req = req;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    drive(1'b0, 2'b11, 3'd0, 3'd0, 8'h00, 1'b0);
    drive(1'b1, 2'b11, 3'd0, 3'd0, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  // Let a just-acked transaction return to idle, then confirm idle.
  task automatic idle_sync();
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      $display("FAIL idle_busy: busy=%b required 0", busy);
      n_err++;
    end
  endtask

  // Raise one request, wait (bounded) for its ack, check latency and rdata.
  task automatic do_req(input bit who, input logic [1:0] op, input logic [2:0] ad,
                        input logic [2:0] ad2, input logic [7:0] wd,
                        input int exp_lat, input logic [7:0] exp_rd, input string tag);
    int n = 0;
    bit got = 1'b0;
    logic [7:0] rd;
    logic other;
    drive(who, op, ad, ad2, wd, 1'b1);
    while (!got && n < 24) begin
      @(posedge clk);
      n++;
      #1;
      got = who ? b_if.ack : a_if.ack;
    end
    n_vec++;
    if (!got) begin
      $display("FAIL %s_timeout: no ack from %s in %0d cycles, ack required", tag, who ? "B" : "A", n);
      n_err++;
    end else begin
      rd    = who ? b_if.rdata : a_if.rdata;
      other = who ? a_if.ack : b_if.ack;
      if (n + 1 !== exp_lat) begin
        $display("FAIL %s_latency: %s op=%0d latency=%0d required %0d", tag, who ? "B" : "A", op, n + 1, exp_lat);
        n_err++;
      end
      n_vec++;
      if (rd !== exp_rd) begin
        $display("FAIL %s_rdata: %s op=%0d rdata=%02h required %02h", tag, who ? "B" : "A", op, rd, exp_rd);
        n_err++;
      end
      n_vec++;
      if (other !== 1'b0) begin
        $display("FAIL %s_other_ack: non-granted ack=%b required 0", tag, other);
        n_err++;
      end
      $display("txn %s %s op=%0d addr=%0d addr2=%0d wdata=%02h latency=%0d rdata=%02h",
               tag, who ? "B" : "A", op, ad, ad2, wd, n + 1, rd);
    end
    if (!who) a_if.req = 1'b0; else b_if.req = 1'b0;
  endtask

  task automatic single(input bit who, input logic [1:0] op, input logic [2:0] ad,
                        input logic [2:0] ad2, input logic [7:0] wd, input string tag);
    logic [7:0] e;
    model_apply(who, op, ad, ad2, wd, e);
    do_req(who, op, ad, ad2, wd, op_cycles(op), e, tag);
    idle_sync();
  endtask

  // Both requesters raise req in the same idle cycle.
  task automatic pair_round(input logic [1:0] opa, input logic [2:0] aa, input logic [2:0] aa2,
                            input logic [7:0] wa, input logic [1:0] opb, input logic [2:0] ba,
                            input logic [2:0] ba2, input logic [7:0] wb, input string tag);
    logic [7:0] ea, eb;
    int la, lb;
    if (ref_last) begin   // B served last: A goes first
      model_apply(1'b0, opa, aa, aa2, wa, ea);
      model_apply(1'b1, opb, ba, ba2, wb, eb);
      la = op_cycles(opa);
      lb = la + op_cycles(opb);
    end else begin
      model_apply(1'b1, opb, ba, ba2, wb, eb);
      model_apply(1'b0, opa, aa, aa2, wa, ea);
      lb = op_cycles(opb);
      la = lb + op_cycles(opa);
    end
    fork
      do_req(1'b0, opa, aa, aa2, wa, la, ea, tag);
      do_req(1'b1, opb, ba, ba2, wb, lb, eb, tag);
    join
    idle_sync();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0;
    drive(1'b0, 2'b11, 3'd0, 3'd0, 8'h00, 1'b0);
    drive(1'b1, 2'b11, 3'd0, 3'd0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    n_vec++; if (busy !== 1'b0)        begin $display("FAIL reset_busy: %b required 0", busy); n_err++; end
    n_vec++; if (rf_load !== 1'b0)     begin $display("FAIL reset_rf_load: %b required 0", rf_load); n_err++; end
    n_vec++; if (rf_sel !== 3'd0)      begin $display("FAIL reset_rf_sel: %0d required 0", rf_sel); n_err++; end
    n_vec++; if (rf_d !== 8'h00)       begin $display("FAIL reset_rf_d: %02h required 00", rf_d); n_err++; end
    n_vec++; if (a_if.ack !== 1'b0)    begin $display("FAIL reset_a_ack: %b required 0", a_if.ack); n_err++; end
    n_vec++; if (b_if.ack !== 1'b0)    begin $display("FAIL reset_b_ack: %b required 0", b_if.ack); n_err++; end
    n_vec++; if (a_if.rdata !== 8'h00) begin $display("FAIL reset_a_rdata: %02h required 00", a_if.rdata); n_err++; end
    n_vec++; if (b_if.rdata !== 8'h00) begin $display("FAIL reset_b_rdata: %02h required 00", b_if.rdata); n_err++; end
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin $display("FAIL reset_release_busy: %b required 0", busy); n_err++; end
  endtask

  task automatic test_write_read();
    logic [7:0] e;
    int l0;
    l0 = load_cnt;
    model_apply(1'b0, 2'b01, 3'd3, 3'd0, 8'h5A, e);
    fork
      do_req(1'b0, 2'b01, 3'd3, 3'd0, 8'h5A, 3, e, "write");
      begin
        @(posedge clk); #2;
        n_vec++;
        if (rf_load !== 1'b1 || rf_sel !== 3'd3 || rf_d !== 8'h5A) begin
          $display("FAIL write_rf_bus: load=%b sel=%0d d=%02h required 1/3/5a", rf_load, rf_sel, rf_d);
          n_err++;
        end
        @(posedge clk); #2;
        n_vec++;
        if (rf_load !== 1'b0 || rf_sel !== 3'd0 || rf_d !== 8'h00) begin
          $display("FAIL write_done_bus: load=%b sel=%0d d=%02h required 0/0/00", rf_load, rf_sel, rf_d);
          n_err++;
        end
      end
    join
    idle_sync();
    n_vec++;
    if (load_cnt - l0 !== 1) begin
      $display("FAIL write_load_cycles: %0d required 1", load_cnt - l0);
      n_err++;
    end
    single(1'b0, 2'b00, 3'd3, 3'd0, 8'h00, "read");
  endtask

  task automatic test_tie_break();
    apply_reset();
    pair_round(2'b01, 3'd4, 3'd0, 8'h11, 2'b00, 3'd4, 3'd0, 8'h00, "tie1");
    single(1'b0, 2'b11, 3'd0, 3'd0, 8'h00, "tie_solo");
    pair_round(2'b00, 3'd4, 3'd0, 8'h00, 2'b01, 3'd4, 3'd0, 8'h22, "tie2");
  endtask

  task automatic test_fairness();
    bit order [$];
    logic [7:0] a_rd = 8'h00;
    logic [7:0] e;
    int n = 0;
    bit b_second = 1'b0;
    apply_reset();
    drive(1'b1, 2'b01, 3'd2, 3'd0, 8'hA7, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 2'b00, 3'd2, 3'd0, 8'h00, 1'b1);
    while (order.size() < 3 && n < 40) begin
      @(posedge clk); n++; #1;
      if (a_if.ack === 1'b1) begin
        order.push_back(1'b0);
        a_rd = a_if.rdata;
        a_if.req = 1'b0;
      end
      if (b_if.ack === 1'b1) begin
        order.push_back(1'b1);
        if (!b_second) begin
          b_second = 1'b1;
          drive(1'b1, 2'b01, 3'd5, 3'd0, 8'h3C, 1'b1);
        end else begin
          b_if.req = 1'b0;
        end
      end
    end
    model_apply(1'b1, 2'b01, 3'd2, 3'd0, 8'hA7, e);
    model_apply(1'b0, 2'b00, 3'd2, 3'd0, 8'h00, e);
    n_vec++;
    if (order.size() != 3) begin
      $display("FAIL fair_count: %0d acks seen required 3", order.size());
      n_err++;
    end else if (order[0] !== 1'b1 || order[1] !== 1'b0 || order[2] !== 1'b1) begin
      $display("FAIL fair_order: %0d,%0d,%0d required 1,0,1 (0=A 1=B)", order[0], order[1], order[2]);
      n_err++;
    end
    n_vec++;
    if (a_rd !== e) begin
      $display("FAIL fair_a_rdata: %02h required %02h", a_rd, e);
      n_err++;
    end
    model_apply(1'b1, 2'b01, 3'd5, 3'd0, 8'h3C, e);
    idle_sync();
    n_vec++;
    if (rf_mem[5] !== ref_mem[5]) begin
      $display("FAIL fair_second_write: r5=%02h required %02h", rf_mem[5], ref_mem[5]);
      n_err++;
    end
    $display("txn fairness ack order %0d,%0d,%0d a_rdata=%02h", order.size() > 0 ? order[0] : 0,
             order.size() > 1 ? order[1] : 0, order.size() > 2 ? order[2] : 0, a_rd);
  endtask

  task automatic test_reset_mid_op();
    bit any_ack = 1'b0;
    bit any_busy = 1'b0;
    apply_reset();
    drive(1'b1, 2'b01, 3'd7, 3'd0, 8'h99, 1'b1);
    @(posedge clk); #1;
    n_vec++;
    if (busy !== 1'b1 || rf_load !== 1'b1) begin
      $display("FAIL midreset_exec: busy=%b rf_load=%b required 1/1", busy, rf_load);
      n_err++;
    end
    #1 reset = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || rf_load !== 1'b0 || b_if.ack !== 1'b0) begin
      $display("FAIL midreset_abort: busy=%b rf_load=%b b_ack=%b required 0/0/0", busy, rf_load, b_if.ack);
      n_err++;
    end
    b_if.req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (6) begin
      @(posedge clk); #1;
      if (b_if.ack !== 1'b0 || a_if.ack !== 1'b0) any_ack = 1'b1;
      if (busy !== 1'b0) any_busy = 1'b1;
    end
    n_vec++;
    if (any_ack || any_busy) begin
      $display("FAIL midreset_after: ack_seen=%b busy_seen=%b required 0/0", any_ack, any_busy);
      n_err++;
    end
    n_vec++;
    if (rf_mem[7] !== ref_mem[7]) begin
      $display("FAIL midreset_r7: %02h required %02h", rf_mem[7], ref_mem[7]);
      n_err++;
    end
    $display("txn reset_mid_op B WRITE aborted");
    @(negedge clk);
  endtask

  task automatic test_move();
    int l0;
    logic [2:0] r;
    apply_reset();
    single(1'b0, 2'b01, 3'd1, 3'd0, 8'hC3, "mv_setup");
    l0 = load_cnt;
    single(1'b0, 2'b10, 3'd1, 3'd6, 8'h00, "move");
    n_vec++;
    if (load_cnt - l0 !== (MOVE_EN ? 1 : 0)) begin
      $display("FAIL move_load_cycles: %0d required %0d", load_cnt - l0, MOVE_EN ? 1 : 0);
      n_err++;
    end
    single(1'b0, 2'b00, 3'd6, 3'd0, 8'h00, "move_check");
    r = 3'($urandom_range(0, 7));
    single(1'b1, 2'b01, r, 3'd0, 8'h6E, "mv_same_setup");
    single(1'b1, 2'b10, r, r, 8'h00, "move_same");
    single(1'b0, 2'b00, r, 3'd0, 8'h00, "move_same_check");
  endtask

  task automatic test_nop();
    int l0;
    single(1'b1, 2'b00, 3'd1, 3'd0, 8'h00, "nop_setup");
    l0 = load_cnt;
    single(1'b1, 2'b11, 3'd2, 3'd4, 8'hFF, "nop");
    n_vec++;
    if (load_cnt - l0 !== 0) begin
      $display("FAIL nop_load_cycles: %0d required 0", load_cnt - l0);
      n_err++;
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      int mode = $urandom_range(0, 2);
      logic [1:0] opa = 2'($urandom_range(0, 3));
      logic [1:0] opb = 2'($urandom_range(0, 3));
      logic [2:0] aa  = 3'($urandom_range(0, 7));
      logic [2:0] aa2 = 3'($urandom_range(0, 7));
      logic [2:0] ba  = 3'($urandom_range(0, 7));
      logic [2:0] ba2 = 3'($urandom_range(0, 7));
      logic [7:0] wa  = 8'($urandom_range(0, 255));
      logic [7:0] wb  = 8'($urandom_range(0, 255));
      if (mode == 0)      single(1'b0, opa, aa, aa2, wa, "rand");
      else if (mode == 1) single(1'b1, opb, ba, ba2, wb, "rand");
      else                pair_round(opa, aa, aa2, wa, opb, ba, ba2, wb, "rand_pair");
    end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (rf_mem[i] !== ref_mem[i]) begin
        $display("FAIL rand_rf_contents: r%0d=%02h required %02h", i, rf_mem[i], ref_mem[i]);
        n_err++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_read();
    test_tie_break();
    test_fairness();
    test_reset_mid_op();
    test_move();
    test_nop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
